// File: rtl/coherence_bus_responder_if.sv
// coherence_bus_responder_if: request/snoop/event bundle between cache controller (master) and bus responder (slave)
interface coherence_bus_responder_if #(parameter int NUM_PEERS = 3) ();
  logic                 Cache_Sector_Fill;
  logic                 Invalidate;
  logic                 AdrRetry;
  logic [NUM_PEERS-1:0] peer_modified;
  logic [NUM_PEERS-1:0] peer_inv_ack;
  logic                 READ_DONE;
  logic                 send_abort;
  logic                 AllInvDone;
  logic                 write_back_done;
  logic                 busy;
  modport master (
    output Cache_Sector_Fill, Invalidate, AdrRetry, peer_modified, peer_inv_ack,
    input  READ_DONE, send_abort, AllInvDone, write_back_done, busy
  );
  modport slave (
    input  Cache_Sector_Fill, Invalidate, AdrRetry, peer_modified, peer_inv_ack,
    output READ_DONE, send_abort, AllInvDone, write_back_done, busy
  );
endinterface

// File: rtl/coherence_bus_responder.sv
// coherence_bus_responder: turns fill/invalidate/retry strobes into registered READ_DONE, send_abort, AllInvDone, write_back_done pulses plus busy; ports: clk, reset (async active-high), bus (slave modport carrying requests, snoop/ack inputs and event outputs)
module coherence_bus_responder #(
  parameter int NUM_PEERS = 3,
  parameter int MEM_LAT   = 4,
  parameter int WB_LAT    = 6,
  parameter int CNT_W     = 4
) (
  input logic                       clk,
  input logic                       reset,
  coherence_bus_responder_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, FILL_WAIT, ABORT, INV_WAIT, WB_WAIT} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PEERS-1:0] mask_q, mask_d;
  logic                 read_done_q, read_done_d;
  logic                 send_abort_q, send_abort_d;
  logic                 all_inv_done_q, all_inv_done_d;
  logic                 wb_done_q, wb_done_d;
  logic                 busy_q, busy_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      read_done_q    <= 1'b0;
      send_abort_q   <= 1'b0;
      all_inv_done_q <= 1'b0;
      wb_done_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      read_done_q    <= read_done_d;
      send_abort_q   <= send_abort_d;
      all_inv_done_q <= all_inv_done_d;
      wb_done_q      <= wb_done_d;
      busy_q         <= busy_d;
    end
  end
  // Each wait state lingers one extra cycle with counter/mask at zero; that
  // cycle is the completion cycle, so outputs are decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (bus.Cache_Sector_Fill) begin
          state_d = |bus.peer_modified ? ABORT : FILL_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else if (bus.Invalidate) begin
          state_d = INV_WAIT;
          mask_d  = '1;
        end else if (bus.AdrRetry) begin
          state_d = WB_WAIT;
          cnt_d   = CNT_W'(WB_LAT - 1);
        end
      end
      FILL_WAIT, WB_WAIT: begin
        state_d = cnt_q == '0 ? IDLE : state_q;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      INV_WAIT: begin
        state_d = mask_q == '0 ? IDLE : INV_WAIT;
        mask_d  = mask_q & ~bus.peer_inv_ack;
      end
      default: state_d = IDLE;
    endcase
    read_done_d    = state_d == FILL_WAIT && cnt_d == '0;
    wb_done_d      = state_d == WB_WAIT && cnt_d == '0;
    all_inv_done_d = state_d == INV_WAIT && mask_d == '0;
    send_abort_d   = state_d == ABORT;
    busy_d         = state_d != IDLE;
  end
  assign bus.READ_DONE       = read_done_q;
  assign bus.send_abort      = send_abort_q;
  assign bus.AllInvDone      = all_inv_done_q;
  assign bus.write_back_done = wb_done_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_coherence_bus_responder.sv
// tb_coherence_bus_responder: table vectors, reset sequences and random traffic against an event-schedule model
module tb_coherence_bus_responder;
  localparam int NP = 3, ML = 4, WL = 6, CW = 4;
  localparam int K_NONE = 0, K_FILL = 1, K_ABORT = 2, K_INV = 3, K_WB = 4;
  typedef struct {
    logic          f, i, r;
    logic [NP-1:0] pm, ack;
    logic [4:0]    exp;
  } vec_t;
  logic clk, reset;
  logic [4:0] dut_o;
  int errors = 0, checks = 0;
  int t = 0, kind = K_NONE, done_at = -1;
  logic [NP-1:0] pend;
  vec_t tab[$], tab6[$];
  coherence_bus_responder_if #(.NUM_PEERS(NP)) bus ();
  coherence_bus_responder #(.NUM_PEERS(NP), .MEM_LAT(ML), .WB_LAT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  assign dut_o = {bus.busy, bus.READ_DONE, bus.send_abort, bus.AllInvDone, bus.write_back_done};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic vec_t mk(logic f, logic i, logic r, logic [NP-1:0] pm, logic [NP-1:0] ack, logic [4:0] exp);
    vec_t v;
    v.f = f; v.i = i; v.r = r; v.pm = pm; v.ack = ack; v.exp = exp;
    return v;
  endfunction
  // Expected outputs for the current cycle: busy while an operation is live,
  // and the operation's event exactly in its scheduled completion cycle.
  function automatic logic [4:0] model_out();
    logic p;
    p = kind != K_NONE && t == done_at;
    return {kind != K_NONE, p && kind == K_FILL, p && kind == K_ABORT, p && kind == K_INV, p && kind == K_WB};
  endfunction
  task automatic model_update(input vec_t v);
    if (kind == K_NONE) begin
      if (v.f) begin
        kind    = v.pm != 0 ? K_ABORT : K_FILL;
        done_at = v.pm != 0 ? t + 1 : t + ML;
      end else if (v.i) begin
        kind    = K_INV;
        pend    = '1;
        done_at = -1;
      end else if (v.r) begin
        kind    = K_WB;
        done_at = t + WL;
      end
    end else if (t == done_at) begin
      kind = K_NONE;
    end else if (kind == K_INV && done_at < 0) begin
      pend = pend & ~v.ack;
      if (pend == 0) done_at = t + 1;
    end
  endtask
  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got {busy,rd,abort,inv,wb}=%b expected %b", name, t, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.Cache_Sector_Fill = v.f;
    bus.Invalidate        = v.i;
    bus.AdrRetry          = v.r;
    bus.peer_modified     = v.pm;
    bus.peer_inv_ack      = v.ack;
  endtask
  task automatic step(input vec_t v, input bit chk_tab);
    drive(v);
    #4;
    check("model", dut_o, model_out());
    if (chk_tab) check("table", dut_o, v.exp);
    model_update(v);
    @(posedge clk);
    #1;
    t++;
  endtask
  initial begin
    vec_t idle, v;
    idle = mk(0, 0, 0, 0, 0, 5'b00000);
    // fill, MEM_LAT=4
    tab.push_back(mk(1, 0, 0, 3'b000, 0, 5'b00000));
    for (int k = 0; k < 3; k++) tab.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b11000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // abort on a modified peer copy
    tab.push_back(mk(1, 0, 0, 3'b010, 0, 5'b00000));
    tab.push_back(mk(0, 0, 0, 3'b010, 0, 5'b10100));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // fill beats invalidate
    tab.push_back(mk(1, 1, 0, 3'b000, 3'b111, 5'b00000));
    for (int k = 0; k < 3; k++) tab.push_back(mk(0, 0, 0, 3'b100, 3'b111, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b111, 5'b11000));
    tab.push_back(mk(0, 0, 0, 0, 3'b111, 5'b00000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // invalidate with staggered acks
    tab.push_back(mk(0, 1, 0, 0, 3'b111, 5'b00000));
    tab.push_back(mk(0, 0, 0, 0, 3'b000, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b001, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b100, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b000, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b011, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 3'b000, 5'b10010));
    tab.push_back(mk(0, 0, 0, 0, 3'b000, 5'b00000));
    // write-back with a dropped fill in cycle 3
    tab.push_back(mk(0, 0, 1, 0, 0, 5'b00000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(1, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab.push_back(mk(0, 0, 0, 0, 0, 5'b10001));
    for (int k = 0; k < 5; k++) tab.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    // after a reset-cancelled fill: silence, then a fresh fill
    for (int k = 0; k < 5; k++) tab6.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    tab6.push_back(mk(1, 0, 0, 0, 0, 5'b00000));
    for (int k = 0; k < 3; k++) tab6.push_back(mk(0, 0, 0, 0, 0, 5'b10000));
    tab6.push_back(mk(0, 0, 0, 0, 0, 5'b11000));
    tab6.push_back(mk(0, 0, 0, 0, 0, 5'b00000));
    reset = 1'b1;
    drive(idle);
    #3;
    check("reset_init", dut_o, 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(idle, 1);
    foreach (tab[k]) step(tab[k], 1);
    // fill interrupted by an asynchronous reset in cycle 2
    step(mk(1, 0, 0, 0, 0, 5'b00000), 1);
    step(mk(0, 0, 0, 0, 0, 5'b10000), 1);
    drive(idle);
    #2;
    check("pre_reset_busy", dut_o, 5'b10000);
    reset = 1'b1;
    #1;
    check("async_reset", dut_o, 5'b00000);
    @(posedge clk);
    #1;
    check("reset_hold", dut_o, 5'b00000);
    reset = 1'b0;
    kind = K_NONE;
    done_at = -1;
    t++;
    foreach (tab6[k]) step(tab6[k], 1);
    for (int k = 0; k < 800; k++) begin
      v.f   = $urandom_range(0, 5) == 0;
      v.i   = $urandom_range(0, 5) == 0;
      v.r   = $urandom_range(0, 5) == 0;
      v.pm  = $urandom_range(0, 2) == 0 ? NP'($urandom) : '0;
      v.ack = $urandom_range(0, 2) == 0 ? NP'($urandom) : '0;
      v.exp = '0;
      step(v, 0);
    end
    for (int k = 0; k < 20; k++) step(idle, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
